// File: rtl/event_readout_buffer.sv
// event_readout_buffer
//   Packs each qualifying detection sample with an 8-bit sample timestamp into
//   a 20-bit record {ts, spike, events}. Records are held in a small FIFO and
//   handed to an external reader as three bytes, one byte per read strobe:
//     byte0 = {4'hA, spike}   (4'hA marks the start of a record)
//     byte1 = events
//     byte2 = timestamp
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   sample_valid            detection inputs valid this cycle (1-cycle pulse)
//   spike_detection_array   per-unit spike flags
//   event_out_array         per-unit 2-bit event codes
//   read_strobe             request for the next output byte
//   clear_overflow          clears overflow and drop_count
//   data_out, data_valid    output byte and its 1-cycle valid pulse
//   fifo_empty, fifo_full   record-level FIFO status
//   fifo_level              records stored, including one partially read
//   overflow, drop_count    sticky drop flag and saturating drop counter
module event_readout_buffer #(
  parameter int FIFO_DEPTH  = 8,
  parameter bit CAPTURE_ALL = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_valid,
  input  logic [3:0]                  spike_detection_array,
  input  logic [7:0]                  event_out_array,
  input  logic                        read_strobe,
  input  logic                        clear_overflow,
  output logic [7:0]                  data_out,
  output logic                        data_valid,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic [7:0]                  drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {B0, B1, B2} byte_state_t;

  byte_state_t     state_reg, state_next;
  logic [19:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [7:0]      ts_reg;
  logic [19:0]     head;
  logic [7:0]      byte_sel;
  logic            capture, rd_fire, pop, push, drop;
  logic [LW-1:0]   level_next;

  assign capture    = sample_valid &&
                      (CAPTURE_ALL || (|spike_detection_array) || (|event_out_array));
  assign rd_fire    = read_strobe && !fifo_empty;
  assign pop        = rd_fire && (state_reg == B2);
  // A pop in the same cycle frees a slot, so a push while full is still taken.
  assign push       = capture && (!fifo_full || pop);
  assign drop       = capture && fifo_full && !pop;
  assign level_next = fifo_level + LW'(push) - LW'(pop);
  assign head       = mem[rd_ptr_reg];

  // Byte FSM: next state and byte selection for the current head record.
  always_comb begin
    state_next = state_reg;
    byte_sel   = 8'h00;
    case (state_reg)
      B0: begin
        byte_sel = {4'hA, head[11:8]};
        if (rd_fire) state_next = B1;
      end
      B1: begin
        byte_sel = head[7:0];
        if (rd_fire) state_next = B2;
      end
      default: begin
        byte_sel = head[19:12];
        if (rd_fire) state_next = B0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= B0;
    else        state_reg <= state_next;
  end

  // Record storage has no reset; validity is tracked by the pointers/level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {ts_reg, spike_detection_array, event_out_array};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ts_reg     <= 8'h00;
      fifo_level <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= 8'h00;
    end else begin
      if (sample_valid) ts_reg <= ts_reg + 8'd1;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      fifo_level <= level_next;
      fifo_empty <= (level_next == '0);
      fifo_full  <= (level_next == LW'(FIFO_DEPTH));
      data_valid <= rd_fire;
      if (rd_fire) data_out <= byte_sel;
      // A drop coinciding with a clear restarts the count at one.
      if (drop) begin
        overflow   <= 1'b1;
        if (clear_overflow)          drop_count <= 8'd1;
        else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end else if (clear_overflow) begin
        overflow   <= 1'b0;
        drop_count <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_event_readout_buffer.sv
module tb_event_readout_buffer;

  localparam int DEPTH = 8;
  localparam bit CAPTURE_ALL = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_valid = 1'b0;
  logic [3:0] spike_detection_array = '0;
  logic [7:0] event_out_array = '0;
  logic       read_strobe = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       fifo_empty;
  logic       fifo_full;
  logic [$clog2(DEPTH):0] fifo_level;
  logic       overflow;
  logic [7:0] drop_count;

  event_readout_buffer #(.FIFO_DEPTH(DEPTH), .CAPTURE_ALL(CAPTURE_ALL)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .spike_detection_array(spike_detection_array), .event_out_array(event_out_array),
    .read_strobe(read_strobe), .clear_overflow(clear_overflow),
    .data_out(data_out), .data_valid(data_valid), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_level(fifo_level), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a queue of whole records plus the reader's byte position.
  typedef struct { logic [3:0] sp; logic [7:0] ev; logic [7:0] ts; } rec_t;
  rec_t       q[$];
  int         m_bidx;
  logic [7:0] m_ts, m_do, m_dc;
  logic       m_dv, m_ovf;

  task automatic model_reset();
    q.delete();
    m_bidx = 0; m_ts = 0; m_do = 0; m_dv = 0; m_ovf = 0; m_dc = 0;
  endtask

  task automatic model_cycle(input bit sv, input logic [3:0] sp, input logic [7:0] ev,
                             input bit rs, input bit clr);
    bit cap, drop;
    drop = 0;
    m_dv = 0;
    if (rs && q.size() > 0) begin
      m_dv = 1;
      case (m_bidx)
        0:       m_do = {4'hA, q[0].sp};
        1:       m_do = q[0].ev;
        default: m_do = q[0].ts;
      endcase
      if (m_bidx == 2) begin m_bidx = 0; q.delete(0); end
      else m_bidx++;
    end
    cap = sv && (CAPTURE_ALL || sp != 0 || ev != 0);
    if (cap) begin
      if (q.size() < DEPTH) q.push_back('{sp: sp, ev: ev, ts: m_ts});
      else drop = 1;
    end
    if (sv) m_ts = m_ts + 8'd1;
    if (drop) begin
      m_ovf = 1;
      m_dc  = clr ? 8'd1 : ((m_dc == 8'hFF) ? 8'hFF : m_dc + 8'd1);
    end else if (clr) begin
      m_ovf = 0; m_dc = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle with the given inputs, compared against the model.
  task automatic step(input bit sv, input logic [3:0] sp, input logic [7:0] ev,
                      input bit rs, input bit clr);
    sample_valid = sv; spike_detection_array = sp; event_out_array = ev;
    read_strobe = rs; clear_overflow = clr;
    @(posedge clk); #1;
    model_cycle(sv, sp, ev, rs, clr);
    vectors++;
    $display("[%0t] sv=%0b sp=%h ev=%h rs=%0b clr=%0b -> do=%h dv=%0b lvl=%0d e=%0b f=%0b ovf=%0b dc=%0d",
             $time, sv, sp, ev, rs, clr, data_out, data_valid, fifo_level,
             fifo_empty, fifo_full, overflow, drop_count);
    if (data_out !== m_do || data_valid !== m_dv || int'(fifo_level) != q.size() ||
        fifo_empty !== (q.size() == 0) || fifo_full !== (q.size() == DEPTH) ||
        overflow !== m_ovf || drop_count !== m_dc) begin
      miscompares++;
      $display("FAIL model: got do=%h dv=%0b lvl=%0d e=%0b f=%0b ovf=%0b dc=%0d expected do=%h dv=%0b lvl=%0d e=%0b f=%0b ovf=%0b dc=%0d",
               data_out, data_valid, fifo_level, fifo_empty, fifo_full, overflow, drop_count,
               m_do, m_dv, q.size(), q.size() == 0, q.size() == DEPTH, m_ovf, m_dc);
    end
    @(negedge clk);
    sample_valid = 0; read_strobe = 0; clear_overflow = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    sample_valid = 0; read_strobe = 0; clear_overflow = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst data_out", data_out, 0);
    chk("rst data_valid", data_valid, 0);
    chk("rst fifo_empty", fifo_empty, 1);
    chk("rst fifo_full", fifo_full, 0);
    chk("rst fifo_level", fifo_level, 0);
    chk("rst overflow", overflow, 0);
    chk("rst drop_count", drop_count, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    bit sv; logic [3:0] sp; logic [7:0] ev; bit rs; bit clr;
    bit edv; logic [7:0] edo; int elvl; bit eempty;
  } vec_t;
  vec_t vecs[10];

  initial begin
    vecs[0] = '{1, 4'h0, 8'h00, 0, 0, 0, 8'h00, 0, 1};
    vecs[1] = '{1, 4'h0, 8'h00, 0, 0, 0, 8'h00, 0, 1};
    vecs[2] = '{1, 4'h0, 8'h00, 0, 0, 0, 8'h00, 0, 1};
    vecs[3] = '{1, 4'h5, 8'h12, 0, 0, 0, 8'h00, 1, 0};
    vecs[4] = '{0, 4'h0, 8'h00, 1, 0, 1, 8'hA5, 1, 0};
    vecs[5] = '{0, 4'h0, 8'h00, 1, 0, 1, 8'h12, 1, 0};
    vecs[6] = '{0, 4'h0, 8'h00, 1, 0, 1, 8'h03, 0, 1};
    vecs[7] = '{0, 4'h0, 8'h00, 1, 0, 0, 8'h03, 0, 1};
    vecs[8] = '{0, 4'h0, 8'h00, 0, 0, 0, 8'h03, 0, 1};
    vecs[9] = '{0, 4'h0, 8'h00, 0, 1, 0, 8'h03, 0, 1};

    model_reset();
    do_reset();

    // Basic record framing from constant expectations.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].sv, vecs[i].sp, vecs[i].ev, vecs[i].rs, vecs[i].clr);
      chk($sformatf("tbl%0d data_valid", i), data_valid, vecs[i].edv);
      chk($sformatf("tbl%0d data_out", i), data_out, vecs[i].edo);
      chk($sformatf("tbl%0d fifo_level", i), fifo_level, vecs[i].elvl);
      chk($sformatf("tbl%0d fifo_empty", i), fifo_empty, vecs[i].eempty);
    end

    // Fill past depth, then drain.
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 4'h1, 8'h00, 0, 0);
    chk("fill fifo_full", fifo_full, 1);
    chk("fill fifo_level", fifo_level, 8);
    chk("fill overflow", overflow, 1);
    chk("fill drop_count", drop_count, 1);
    for (int i = 0; i < 24; i++) step(0, 0, 0, 1, 0);
    chk("drain last ts", data_out, 8'h07);
    chk("drain empty", fifo_empty, 1);

    // Full with head at byte2: pop and push together.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 4'h2, 8'h00, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 4'h9, 8'h44, 1, 0);
    chk("pushpop overflow", overflow, 0);
    chk("pushpop level", fifo_level, 8);
    for (int i = 0; i < 24; i++) step(0, 0, 0, 1, 0);
    chk("pushpop last ts", data_out, 8'h08);
    // Strobe on empty FIFO leaves data_out alone.
    step(0, 0, 0, 1, 0);
    chk("empty strobe dv", data_valid, 0);
    chk("empty strobe do", data_out, 8'h08);

    // Timestamp wrap.
    do_reset();
    for (int i = 0; i < 256; i++) step(1, 4'h0, 8'h00, 0, 0);
    step(1, 4'h1, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("wrap ts", data_out, 8'h00);

    // Reset mid-record.
    do_reset();
    step(1, 4'h3, 8'h21, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    do_reset();
    step(1, 4'h6, 8'h00, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("post-reset byte0", data_out, 8'hA6);

    // Drop counter saturation and clear interaction.
    do_reset();
    for (int i = 0; i < 8 + 300; i++) step(1, 4'h1, 8'h00, 0, 0);
    chk("sat drop_count", drop_count, 255);
    step(1, 4'h1, 8'h00, 0, 1);
    chk("clr+drop overflow", overflow, 1);
    chk("clr+drop drop_count", drop_count, 1);
    step(0, 0, 0, 0, 1);
    chk("clr overflow", overflow, 0);
    chk("clr drop_count", drop_count, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] sp;
      logic [7:0] ev;
      sp = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      ev = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      step($urandom_range(0, 1) == 1, sp, ev, $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
